// File: rtl/wired_lsu_mem_pipe.sv
// In-order load/store unit memory stage: tracker ring, one-deep mem staging
// register, data barrier and flush handling with orphaned-response discard.
module wired_lsu_mem_pipe #(
  parameter int RID_W = 6,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [RID_W-1:0] req_wid_i,
  input  logic [31:0]      req_vaddr_i,
  input  logic [1:0]       req_msize_i,
  input  logic             req_msigned_i,
  input  logic [3:0]       req_strb_i,
  input  logic [31:0]      req_wdata_i,
  input  logic             req_dbar_i,
  output logic             mem_req_valid_o,
  input  logic             mem_req_ready_i,
  output logic [31:0]      mem_addr_o,
  output logic             mem_we_o,
  output logic [3:0]       mem_strb_o,
  output logic [31:0]      mem_wdata_o,
  input  logic             mem_resp_valid_i,
  input  logic [31:0]      mem_rdata_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [RID_W-1:0] resp_wid_o,
  output logic [31:0]      resp_rdata_o,
  output logic [31:0]      resp_vaddr_o,
  output logic             resp_excp_o
);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [RID_W-1:0] wid;
    logic [31:0]      vaddr;
    logic [1:0]       msize;
    logic             msigned;
    logic             loc;
    logic             excp;
    logic             done;
    logic             st;
    logic [31:0]      rdata;
  } ent_t;

  ent_t          ent [DEPTH];
  logic [PW-1:0] aptr, rptr, dbar_idx, scan_idx, out_idx;
  logic [PW:0]   cnt, inflight, orphan;
  logic [PW+1:0] orphan_sum;
  logic          dbar_pend, out_found, accept, mis, is_local, mem_hs, resp_hs, rsp_live;

  function automatic logic [31:0] extract(input logic [31:0] d, input logic [1:0] a,
                                          input logic [1:0] sz, input logic sg);
    logic [31:0] b, h;
    b = d >> {a, 3'b000};
    h = d >> {a[1], 4'b0000};
    case (sz)
      2'd0:    extract = {{24{sg & b[7]}}, b[7:0]};
      2'd1:    extract = {{16{sg & h[15]}}, h[15:0]};
      default: extract = d;
    endcase
  endfunction

  assign mis      = (req_msize_i == 2'd1 && req_vaddr_i[0]) ||
                    (req_msize_i == 2'd2 && req_vaddr_i[1:0] != 2'b00);
  assign is_local = req_dbar_i | mis;
  assign req_ready_o = (cnt < (PW+1)'(DEPTH)) && !dbar_pend && orphan == '0 &&
                       (!mem_req_valid_o || mem_req_ready_i);
  assign accept   = req_valid_i & req_ready_o;
  assign mem_hs   = mem_req_valid_o & mem_req_ready_i;
  assign rsp_live = mem_resp_valid_i && orphan == '0;

  assign resp_valid_o = (cnt != '0) && ent[rptr].done;
  assign resp_hs      = resp_valid_o & resp_ready_i;
  assign resp_wid_o   = ent[rptr].wid;
  assign resp_rdata_o = ent[rptr].rdata;
  assign resp_vaddr_o = ent[rptr].vaddr;
  assign resp_excp_o  = ent[rptr].excp;

  // Requests handshaken but unanswered at flush become orphans to be dropped.
  assign orphan_sum = {1'b0, orphan} + {1'b0, inflight} + (PW+2)'(mem_hs)
                    - (PW+2)'(mem_resp_valid_i);

  // Oldest live non-local entry still waiting for memory data.
  always_comb begin
    out_found = 1'b0;
    out_idx   = rptr;
    scan_idx  = rptr;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = rptr + PW'(i);
      if (!out_found && (PW+1)'(i) < cnt && !ent[scan_idx].loc && !ent[scan_idx].done) begin
        out_found = 1'b1;
        out_idx   = scan_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      aptr            <= '0;
      rptr            <= '0;
      cnt             <= '0;
      dbar_pend       <= 1'b0;
      dbar_idx        <= '0;
      mem_req_valid_o <= 1'b0;
      mem_addr_o      <= '0;
      mem_we_o        <= 1'b0;
      mem_strb_o      <= '0;
      mem_wdata_o     <= '0;
      inflight        <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i].done <= 1'b0;
      if (!rst_n) orphan <= '0;
      else        orphan <= orphan_sum[PW:0];
    end else begin
      cnt      <= cnt + (PW+1)'(accept) - (PW+1)'(resp_hs);
      inflight <= inflight + (PW+1)'(mem_hs) - (PW+1)'(rsp_live);
      if (mem_resp_valid_i && orphan != '0) orphan <= orphan - (PW+1)'(1);

      if (accept) begin
        ent[aptr] <= '{wid: req_wid_i, vaddr: req_vaddr_i, msize: req_msize_i,
                       msigned: req_msigned_i, loc: is_local,
                       excp: mis & ~req_dbar_i, done: mis & ~req_dbar_i,
                       st: |req_strb_i, rdata: 32'h0};
        aptr <= aptr + PW'(1);
        if (req_dbar_i) begin
          dbar_pend <= 1'b1;
          dbar_idx  <= aptr;
        end
      end

      if (accept && !is_local) begin
        mem_req_valid_o <= 1'b1;
        mem_addr_o      <= {req_vaddr_i[31:2], 2'b00};
        mem_we_o        <= |req_strb_i;
        mem_strb_o      <= req_strb_i;
        mem_wdata_o     <= req_wdata_i;
      end else if (mem_hs) begin
        mem_req_valid_o <= 1'b0;
      end

      if (rsp_live && out_found) begin
        ent[out_idx].done  <= 1'b1;
        ent[out_idx].rdata <= ent[out_idx].st ? 32'h0 :
                              extract(mem_rdata_i, ent[out_idx].vaddr[1:0],
                                      ent[out_idx].msize, ent[out_idx].msigned);
      end

      // The barrier is always the youngest entry, so any outstanding access is older.
      if (dbar_pend && !out_found) ent[dbar_idx].done <= 1'b1;

      if (resp_hs) begin
        rptr <= rptr + PW'(1);
        if (dbar_pend && rptr == dbar_idx) dbar_pend <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_wired_lsu_mem_pipe.sv
// Scoreboard bench: directed loads/stores/barriers/flush with hand-computed results.
module tb_wired_lsu_mem_pipe;
  localparam int RID_W = 6;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n, flush_i, req_valid_i, req_ready_o;
  logic [RID_W-1:0] req_wid_i;
  logic [31:0]      req_vaddr_i, req_wdata_i;
  logic [1:0]       req_msize_i;
  logic             req_msigned_i, req_dbar_i;
  logic [3:0]       req_strb_i;
  logic             mem_req_valid_o, mem_req_ready_i, mem_we_o;
  logic [31:0]      mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]       mem_strb_o;
  logic             mem_resp_valid_i;
  logic             resp_valid_o, resp_ready_i, resp_excp_o;
  logic [RID_W-1:0] resp_wid_o;
  logic [31:0]      resp_rdata_o, resp_vaddr_o;

  typedef struct {
    logic [RID_W-1:0] wid;
    logic [31:0]      rdata;
    logic [31:0]      vaddr;
    logic             excp;
  } rsp_t;
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } mreq_t;

  rsp_t        exp_q[$];
  mreq_t       mem_q[$];
  logic [31:0] pend[$];
  rsp_t        got;
  mreq_t       mgot;
  int          checks = 0;
  int          errors = 0;
  logic        mem_hold = 1'b0;
  logic        rst_junk = 1'b1;

  wired_lsu_mem_pipe #(.RID_W(RID_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_wid_i(req_wid_i),
    .req_vaddr_i(req_vaddr_i), .req_msize_i(req_msize_i), .req_msigned_i(req_msigned_i),
    .req_strb_i(req_strb_i), .req_wdata_i(req_wdata_i), .req_dbar_i(req_dbar_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_strb_o(mem_strb_o),
    .mem_wdata_o(mem_wdata_o), .mem_resp_valid_i(mem_resp_valid_i), .mem_rdata_i(mem_rdata_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_wid_o(resp_wid_o),
    .resp_rdata_o(resp_rdata_o), .resp_vaddr_o(resp_vaddr_o), .resp_excp_o(resp_excp_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [RID_W-1:0] w, input logic [31:0] va, input logic [1:0] sz,
                       input logic sg, input logic [3:0] st, input logic [31:0] wd,
                       input logic db);
    int n;
    req_valid_i = 1'b1; req_wid_i = w; req_vaddr_i = va; req_msize_i = sz;
    req_msigned_i = sg; req_strb_i = st; req_wdata_i = wd; req_dbar_i = db;
    n = 0;
    @(negedge clk);
    while (!req_ready_o && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!req_ready_o) begin
      checks++; errors++;
      $display("FAIL issue_accept wid=%h actual=not_ready required=ready", w);
      req_valid_i = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      req_valid_i = 1'b0;
    end
  endtask

  task automatic load(input logic [RID_W-1:0] w, input logic [31:0] va, input logic [1:0] sz,
                      input logic sg, input logic [31:0] mdata, input logic [31:0] rd);
    mem_q.push_back('{{va[31:2], 2'b00}, 1'b0, 4'h0, 32'h0, mdata});
    exp_q.push_back('{w, rd, va, 1'b0});
    issue(w, va, sz, sg, 4'h0, 32'h0, 1'b0);
  endtask

  task automatic store(input logic [RID_W-1:0] w, input logic [31:0] va, input logic [1:0] sz,
                       input logic [3:0] st, input logic [31:0] wd);
    mem_q.push_back('{{va[31:2], 2'b00}, 1'b1, st, wd, 32'hAAAA_AAAA});
    exp_q.push_back('{w, 32'h0, va, 1'b0});
    issue(w, va, sz, 1'b0, st, wd, 1'b0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mem_q.size() != 0 || pend.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(exp_q.size() + mem_q.size() + pend.size()), 32'd0);
    sync();
  endtask

  // Memory model: answers in order, one per handshake, stalled by mem_hold.
  initial begin
    mem_resp_valid_i = 1'b1;
    mem_rdata_i      = 32'hFFFF_FFFF;
    forever begin
      @(posedge clk);
      #2;
      if (rst_junk) begin
        mem_resp_valid_i = 1'b1;
      end else if (!mem_hold && pend.size() > 0) begin
        mem_resp_valid_i = 1'b1;
        mem_rdata_i      = pend.pop_front();
      end else begin
        mem_resp_valid_i = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && mem_req_valid_o && mem_req_ready_i) begin
      if (mem_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL mem_unexpected actual=%h required=none", mem_addr_o);
      end else begin
        mgot = mem_q.pop_front();
        chk("mem_addr", mem_addr_o, mgot.addr);
        chk("mem_we", 32'(mem_we_o), 32'(mgot.we));
        chk("mem_strb", 32'(mem_strb_o), 32'(mgot.strb));
        chk("mem_wdata", mem_wdata_o, mgot.wdata);
        pend.push_back(mgot.rdata);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && resp_valid_o && resp_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL resp_unexpected actual=%h required=none", resp_wid_o);
      end else begin
        got = exp_q.pop_front();
        chk("resp_wid", 32'(resp_wid_o), 32'(got.wid));
        chk("resp_rdata", resp_rdata_o, got.rdata);
        chk("resp_vaddr", resp_vaddr_o, got.vaddr);
        chk("resp_excp", 32'(resp_excp_o), 32'(got.excp));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; flush_i = 1'b0; req_valid_i = 1'b0; req_wid_i = '0; req_vaddr_i = '0;
    req_msize_i = '0; req_msigned_i = 1'b0; req_strb_i = '0; req_wdata_i = '0;
    req_dbar_i = 1'b0; mem_req_ready_i = 1'b1; resp_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_resp_valid_junk", 32'(resp_valid_o), 32'd0);
    rst_junk = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready_o), 32'd1);
    chk("rst_mem_valid", 32'(mem_req_valid_o), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid_o), 32'd0);
    sync();

    // Extraction patterns and stores.
    load(6'd1, 32'h0000_1003, 2'd0, 1'b1, 32'h80FF_FF00, 32'hFFFF_FF80);
    load(6'd2, 32'h0000_1002, 2'd1, 1'b0, 32'h80FF_FF00, 32'h0000_80FF);
    load(6'd3, 32'h0000_1000, 2'd1, 1'b1, 32'h1234_8001, 32'hFFFF_8001);
    load(6'd4, 32'h0000_1001, 2'd0, 1'b0, 32'h80FF_FF00, 32'h0000_00FF);
    load(6'd5, 32'h0000_1004, 2'd2, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    store(6'd6, 32'h0000_3000, 2'd2, 4'hF, 32'h1122_3344);
    store(6'd7, 32'h0000_3002, 2'd0, 4'h4, 32'h0055_0000);
    wait_idle();

    // Misaligned accesses stay in order behind an outstanding word load.
    mem_hold = 1'b1;
    load(6'd10, 32'h0000_2004, 2'd2, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D);
    exp_q.push_back('{6'd11, 32'h0, 32'h0000_2001, 1'b1});
    issue(6'd11, 32'h0000_2001, 2'd1, 1'b1, 4'h0, 32'h0, 1'b0);
    exp_q.push_back('{6'd12, 32'h0, 32'h0000_2006, 1'b1});
    issue(6'd12, 32'h0000_2006, 2'd2, 1'b0, 4'h0, 32'h0, 1'b0);
    repeat (3) @(negedge clk);
    chk("misal_blocked_head", 32'(resp_valid_o), 32'd0);
    mem_hold = 1'b0;
    wait_idle();

    // Tracker fills at DEPTH, resumes once the head retires.
    mem_hold = 1'b1;
    for (int i = 0; i < DEPTH; i++)
      load(RID_W'(20 + i), 32'h0000_4000 + 32'(4 * i), 2'd2, 1'b0,
           32'hA000_0000 + 32'(i), 32'hA000_0000 + 32'(i));
    @(negedge clk);
    chk("full_ready_low", 32'(req_ready_o), 32'd0);
    sync();
    fork
      load(6'd24, 32'h0000_4010, 2'd2, 1'b0, 32'hB0B0_B0B0, 32'hB0B0_B0B0);
      begin
        repeat (3) @(negedge clk);
        mem_hold = 1'b0;
      end
    join
    wait_idle();

    // Store, barrier, then load: barrier waits for the store.
    mem_hold = 1'b1;
    store(6'd30, 32'h0000_5000, 2'd2, 4'hF, 32'h0BAD_F00D);
    exp_q.push_back('{6'd31, 32'h0, 32'h0000_5008, 1'b0});
    issue(6'd31, 32'h0000_5008, 2'd2, 1'b0, 4'h0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("dbar_ready_low", 32'(req_ready_o), 32'd0);
      chk("dbar_no_resp", 32'(resp_valid_o), 32'd0);
    end
    mem_hold = 1'b0;
    sync();
    load(6'd32, 32'h0000_500C, 2'd0, 1'b1, 32'h0000_00A5, 32'hFFFF_FFA5);
    chk("dbar_retired_first", 32'(exp_q.size()), 32'd1);
    wait_idle();

    // Flush with two requests in flight: both answers dropped.
    mem_hold = 1'b1;
    mem_q.push_back('{32'h0000_7000, 1'b0, 4'h0, 32'h0, 32'h1111_1111});
    issue(6'd60, 32'h0000_7000, 2'd2, 1'b0, 4'h0, 32'h0, 1'b0);
    mem_q.push_back('{32'h0000_7004, 1'b0, 4'h0, 32'h0, 32'h2222_2222});
    issue(6'd61, 32'h0000_7004, 2'd2, 1'b0, 4'h0, 32'h0, 1'b0);
    sync();
    flush_i = 1'b1;
    sync();
    flush_i = 1'b0;
    @(negedge clk);
    chk("orphan_ready_low", 32'(req_ready_o), 32'd0);
    mem_hold = 1'b0;
    n = 0;
    while (!req_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("orphan_ready_back", 32'(req_ready_o), 32'd1);
    chk("orphan_all_dropped", 32'(pend.size()), 32'd0);
    sync();
    load(6'd62, 32'h0000_7008, 2'd1, 1'b1, 32'h1234_8000, 32'hFFFF_8000);
    wait_idle();

    // Response backpressure with a full tracker.
    resp_ready_i = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      load(RID_W'(40 + i), 32'h0000_8000 + 32'(4 * i), 2'd2, 1'b0,
           32'hC000_0000 + 32'(i), 32'hC000_0000 + 32'(i));
    repeat (6) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(resp_valid_o), 32'd1);
      chk("hold_wid", 32'(resp_wid_o), 32'd40);
      chk("hold_rdata", resp_rdata_o, 32'hC000_0000);
      chk("hold_vaddr", resp_vaddr_o, 32'h0000_8000);
      chk("hold_full_ready", 32'(req_ready_o), 32'd0);
    end
    sync();
    resp_ready_i = 1'b1;
    wait_idle();

    // Memory backpressure keeps the staging register stable.
    mem_req_ready_i = 1'b0;
    load(6'd50, 32'h0000_6000, 2'd1, 1'b0, 32'h0000_1234, 32'h0000_1234);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_mem_valid", 32'(mem_req_valid_o), 32'd1);
      chk("stall_mem_addr", mem_addr_o, 32'h0000_6000);
      chk("stall_ready_low", 32'(req_ready_o), 32'd0);
    end
    sync();
    mem_req_ready_i = 1'b1;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
